// File: rtl/ipsxe_floating_point_accum_stim_gen_pkg.sv
// Shared types and defaults for the accumulator example-design stimulus generator.
// The DEPTH/ADDR_W defaults here must match the operand and tlast ROMs.
package ipsxe_floating_point_accum_stim_gen_pkg;

    localparam int unsigned DefDataW  = 32;
    localparam int unsigned DefAddrW  = 4;
    localparam int unsigned DefDepth  = 10;
    localparam int unsigned DefPasses = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_skid2.sv
// Two-entry FIFO that absorbs the one-cycle ROM read latency under backpressure.
// The head entry only changes on a pop, or on a push into an empty buffer.
module ipsxe_floating_point_skid2 #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;

    assign dout  = head_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_accum_stim_gen.sv
// Walks the operand/tlast ROM addresses and replays their contents as an AXI4-Stream
// master sequence into the floating-point accumulator, reporting busy/done to the checker.
module ipsxe_floating_point_accum_stim_gen
    import ipsxe_floating_point_accum_stim_gen_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned PASSES = DefPasses
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_last,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [15:0]       beat_cnt
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       pass_q;
    logic              in_flight_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       beat_cnt_q;

    logic [DATA_W:0]   head;
    logic              skid_full;
    logic              skid_empty;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              last_addr;
    logic              last_pass;
    logic              drain_empty;

    ipsxe_floating_point_skid2 #(
        .WIDTH(DATA_W + 1)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight_q),
        .din   ({rom_last, rom_data}),
        .pop   (pop),
        .dout  (head),
        .full  (skid_full),
        .empty (skid_empty)
    );

    assign occ = skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1);
    assign pop = m_axis_tvalid & m_axis_tready;

    // A beat leaving this cycle frees its slot in time for a read issued now, which is
    // what keeps the stream bubble-free under continuous tready.
    assign issue = (state_q == StRun) &&
                   (({1'b0, occ} + {2'b0, in_flight_q}) < (3'd2 + {2'b0, pop}));

    assign last_addr   = (addr_q == ADDR_W'(DEPTH - 1));
    assign last_pass   = (PASSES != 0) && (pass_q == 16'(PASSES - 1));
    // Skid will be empty after this edge with nothing left to land.
    assign drain_empty = !in_flight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pass_q      <= '0;
            in_flight_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            in_flight_q <= issue;
            done_q      <= 1'b0;
            if (pop) begin
                beat_cnt_q <= sat_inc(beat_cnt_q);
            end
            if (issue) begin
                if (last_addr) begin
                    addr_q <= '0;
                    pass_q <= pass_q + 16'd1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRun;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                        addr_q     <= '0;
                        pass_q     <= '0;
                    end
                end
                StRun: begin
                    if (issue && last_addr && last_pass) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_empty) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rom_addr      = addr_q;
    assign m_axis_tvalid = !skid_empty;
    assign m_axis_tdata  = head[DATA_W-1:0];
    assign m_axis_tlast  = head[DATA_W];
    assign busy          = busy_q;
    assign done          = done_q;
    assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_ipsxe_floating_point_accum_stim_gen.sv
// Bench for the accumulator stimulus generator: two instances (PASSES=1 and PASSES=3)
// fed by bench ROMs, checked every cycle against a queue-based beat model.
module tb_ipsxe_floating_point_accum_stim_gen;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start  [2];
    logic        tready [2];

    int unsigned tests;
    int unsigned fails;
    int unsigned cyc;

    int unsigned acc_cnt         [2];
    int unsigned done_seen       [2];
    int unsigned done_hw         [2];
    int unsigned start_cyc       [2];
    int unsigned first_valid_cyc [2];
    int unsigned first_hs_cyc    [2];
    int unsigned last_hs_cyc     [2];
    bit          seen_valid      [2];
    logic [DEPTH-1:0] last_mask  [2];

    logic [DW-1:0] rom_tab [16];
    logic [15:0]   last_tab;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned NP = (g == 0) ? 1 : 3;

        logic [AW-1:0] rom_addr;
        logic [DW-1:0] rom_data;
        logic          rom_last;
        logic          tvalid;
        logic [DW-1:0] tdata;
        logic          tlast;
        logic          busy;
        logic          done;
        logic [15:0]   beat_cnt;

        ipsxe_floating_point_accum_stim_gen #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .DEPTH  (DEPTH),
            .PASSES (NP)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start[g]),
            .rom_addr      (rom_addr),
            .rom_data      (rom_data),
            .rom_last      (rom_last),
            .m_axis_tvalid (tvalid),
            .m_axis_tready (tready[g]),
            .m_axis_tdata  (tdata),
            .m_axis_tlast  (tlast),
            .busy          (busy),
            .done          (done),
            .beat_cnt      (beat_cnt)
        );

        // Registered ROMs, one-cycle read latency.
        always @(posedge clk) begin
            rom_data <= rom_tab[rom_addr];
            rom_last <= last_tab[rom_addr];
        end

        logic [DW:0] exp_q [$];
        bit          active;
        bit          exp_done;
        bit          prev_stall;

        always @(negedge clk) begin
            if (!rst_n) begin
                check($sformatf("dut%0d_reset_outputs", g),
                      {rom_addr, tvalid, tdata, tlast, busy, done, beat_cnt}, 64'd0);
                exp_q.delete();
                active     = 0;
                exp_done   = 0;
                prev_stall = 0;
                acc_cnt[g] = 0;
            end else begin
                bit          hs;
                bit          idle_now;
                int unsigned lead;
                check($sformatf("dut%0d_busy", g), busy, active);
                check($sformatf("dut%0d_done", g), done, exp_done);
                check($sformatf("dut%0d_beat_cnt", g), beat_cnt,
                      (acc_cnt[g] > 65535) ? 65535 : acc_cnt[g]);
                if (prev_stall) check($sformatf("dut%0d_stall_hold", g), tvalid, 1'b1);
                if (tvalid) begin
                    if (exp_q.size() == 0) check($sformatf("dut%0d_spurious_tvalid", g), tvalid, 1'b0);
                    else check($sformatf("dut%0d_beat%0d", g, acc_cnt[g]), {tlast, tdata}, exp_q[0]);
                end
                if (active) begin
                    lead = (int'(rom_addr) + DEPTH - (acc_cnt[g] % DEPTH)) % DEPTH;
                    check($sformatf("dut%0d_addr_lead_le2", g), lead <= 2, 1'b1);
                end else begin
                    check($sformatf("dut%0d_idle_addr", g), rom_addr, '0);
                end
                if (done) done_hw[g]++;

                // Advance the model by what happens at the coming edge.
                hs       = tvalid && tready[g] && (exp_q.size() > 0);
                idle_now = !active && !exp_done;
                exp_done = 0;
                if (tvalid && !seen_valid[g]) begin
                    seen_valid[g]      = 1;
                    first_valid_cyc[g] = cyc;
                end
                if (hs) begin
                    void'(exp_q.pop_front());
                    if (acc_cnt[g] == 0) first_hs_cyc[g] = cyc;
                    last_hs_cyc[g] = cyc;
                    if (acc_cnt[g] < DEPTH && tlast) last_mask[g][acc_cnt[g]] = 1'b1;
                    acc_cnt[g]++;
                    if (exp_q.size() == 0) begin
                        exp_done = 1;
                        active   = 0;
                        done_seen[g]++;
                    end
                end
                prev_stall = tvalid && !tready[g];
                if (start[g] && idle_now) begin
                    active       = 1;
                    acc_cnt[g]   = 0;
                    done_hw[g]   = 0;
                    seen_valid[g] = 0;
                    start_cyc[g] = cyc;
                    last_mask[g] = '0;
                    for (int p = 0; p < NP; p++) begin
                        for (int i = 0; i < DEPTH; i++) exp_q.push_back({last_tab[i], rom_tab[i]});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 16; i++) rom_tab[i] = $urandom;
    endtask

    task automatic pulse_start(input int idx);
        start[idx] = 1'b1;
        tick();
        start[idx] = 1'b0;
    endtask

    // mode 0: tready high, 1: pattern 1,0,0,1, 2: random. restart_at pulses an extra start.
    task automatic wait_done(input int idx, input int mode, input int budget, input int restart_at);
        int unsigned d0 = done_seen[idx];
        int n = 0;
        while (done_seen[idx] == d0 && n < budget) begin
            case (mode)
                0:       tready[idx] = 1'b1;
                1:       tready[idx] = ((n % 4) == 0) || ((n % 4) == 3);
                default: tready[idx] = 1'($urandom_range(0, 1));
            endcase
            start[idx] = (n == restart_at);
            tick();
            n++;
        end
        start[idx] = 1'b0;
        check($sformatf("dut%0d_done_within_budget", idx), done_seen[idx] != d0, 1'b1);
        repeat (3) tick();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        last_tab = 16'h0280;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tready[0] = 1'b0;
        tready[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            acc_cnt[k]   = 0;
            done_seen[k] = 0;
            done_hw[k]   = 0;
        end
        load_rom();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset: no start, tvalid/busy/rom_addr must stay quiet.
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        repeat (20) tick();

        // Streaming with tready high.
        load_rom();
        pulse_start(0);
        wait_done(0, 0, 100, -1);
        check("stream_beat_cnt", g_inst[0].beat_cnt, 16'd10);
        check("stream_tlast_beats", last_mask[0], 10'h280);
        check("stream_consecutive", last_hs_cyc[0] - first_hs_cyc[0], 9);
        check("stream_first_tvalid_latency", first_valid_cyc[0] - start_cyc[0], 3);
        check("stream_done_pulses", done_hw[0], 1);

        // Backpressure 1,0,0,1 with an ignored start mid-run.
        load_rom();
        pulse_start(0);
        wait_done(0, 1, 300, 7);
        check("bp_beat_cnt", g_inst[0].beat_cnt, 16'd10);
        check("bp_done_pulses", done_hw[0], 1);

        // Three passes under random backpressure.
        load_rom();
        pulse_start(1);
        wait_done(1, 2, 600, -1);
        check("passes_beat_cnt", g_inst[1].beat_cnt, 16'd30);
        check("passes_model_beats", acc_cnt[1], 30);
        check("passes_done_pulses", done_hw[1], 1);

        // Reset mid-run after beat 4 while stalled.
        load_rom();
        tready[0] = 1'b1;
        pulse_start(0);
        for (int n = 0; n < 50 && acc_cnt[0] < 5; n++) tick();
        tready[0] = 1'b0;
        repeat (2) tick();
        check("midrun_stalled_valid", g_inst[0].tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("midrun_async_tvalid_drop", g_inst[0].tvalid, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tready[0] = 1'b1;
        repeat (10) tick();
        pulse_start(0);
        wait_done(0, 0, 100, -1);
        check("midrun_restart_beat_cnt", g_inst[0].beat_cnt, 16'd10);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            load_rom();
            pulse_start(0);
            wait_done(0, 2, 400, -1);
            check($sformatf("rand%0d_beat_cnt", r), g_inst[0].beat_cnt, 16'd10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
